// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (B wins on collision), optional write-to-read bypass and a busy scoreboard.
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WEA,
    input  logic [ADDR_W-1:0]        AA,
    input  logic [WIDTH-1:0]         WDA,
    input  logic                     WEB,
    input  logic [ADDR_W-1:0]        AB,
    input  logic [WIDTH-1:0]         WDB,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*WIDTH-1:0]  RD,
    output logic [NUM_RD-1:0]        RBUSY,
    input  logic                     SB_SET,
    input  logic [ADDR_W-1:0]        SB_ADDR,
    output logic                     WR_CONFLICT
);

    localparam int unsigned       NREGS_U  = NUM_REGS;
    localparam logic [ADDR_W:0]   NREG_LIM = (ADDR_W+1)'(NUM_REGS);

    logic [WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wa_ok;
    logic                wb_ok;
    logic                sb_ok;

    // Address is backed by real storage (in range, and not the hardwired zero register).
    function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREG_LIM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wa_ok = WEA    && valid_addr(AA);
    assign wb_ok = WEB    && valid_addr(AB);
    assign sb_ok = SB_SET && valid_addr(SB_ADDR);

    always_comb begin
        busy_nxt = busy;
        for (int unsigned r = 0; r < NREGS_U; r++) begin
            if ((wa_ok && AA == ADDR_W'(r)) || (wb_ok && AB == ADDR_W'(r)))
                busy_nxt[r] = 1'b0;
            // Set after clear: a newly issued producer supersedes the retiring one.
            if (sb_ok && SB_ADDR == ADDR_W'(r))
                busy_nxt[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREGS_U; r++)
                mem[r] <= '0;
            busy        <= '0;
            WR_CONFLICT <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREGS_U; r++) begin
                if (wb_ok && AB == ADDR_W'(r))
                    mem[r] <= WDB;
                else if (wa_ok && AA == ADDR_W'(r))
                    mem[r] <= WDA;
            end
            busy        <= busy_nxt;
            WR_CONFLICT <= wa_ok && wb_ok && (AA == AB);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  data;
        logic              bsy;
        logic              hit_a;
        logic              hit_b;

        assign ra = RA[i*ADDR_W +: ADDR_W];

        always_comb begin
            data  = '0;
            bsy   = 1'b0;
            hit_a = (BYPASS != 0) && wa_ok && (AA == ra);
            hit_b = (BYPASS != 0) && wb_ok && (AB == ra);
            if (valid_addr(ra)) begin
                for (int unsigned r = 0; r < NREGS_U; r++) begin
                    if (ra == ADDR_W'(r)) begin
                        data = mem[r];
                        bsy  = busy[r];
                    end
                end
            end
            if (hit_b)
                data = WDB;
            else if (hit_a)
                data = WDA;
            if (hit_a || hit_b)
                bsy = 1'b0;
            // Outputs are forced quiet while reset is held, even if a bypass would apply.
            if (!rst) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign RD[i*WIDTH +: WIDTH] = data;
        assign RBUSY[i]             = bsy;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the core register file.
- Provides NUM_RD combinational read ports and two synchronous write ports: A (ALU writeback) and B (load/mem writeback).
- Optional write-to-read bypass and a register-zero-hardwired mode.
- Per-register busy scoreboard lets the decode stage stall on pending writes. Sits between decode (reads, busy set) and writeback (writes, busy clear).

Parameters:
- WIDTH, 32, data width of every register.
- NUM_REGS, 32, number of architectural registers (2..2**ADDR_W).
- ADDR_W, 5, register address width.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- WEA  in  1  write enable, port A.
- AA  in  ADDR_W  write address, port A.
- WDA  in  WIDTH  write data, port A.
- WEB  in  1  write enable, port B.
- AB  in  ADDR_W  write address, port B.
- WDB  in  WIDTH  write data, port B.
- RA  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- RD  out  NUM_RD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH].
- RBUSY  out  NUM_RD  per-port busy (pending write) indication.
- SB_SET  in  1  mark register SB_ADDR busy (instruction issued).
- SB_ADDR  in  ADDR_W  register to mark busy.
- WR_CONFLICT  out  1  registered pulse: both ports wrote the same address last cycle.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-operation):
  - all registers cleared to 0, all busy bits cleared, WR_CONFLICT=0.
  - RD reads 0 and RBUSY reads 0 while reset is held.
- Writes, on the rising clk edge when rst=1:
  - WEA=1 writes WDA to reg[AA]; WEB=1 writes WDB to reg[AB].
  - Both enabled with AA==AB: port B wins, and WR_CONFLICT=1 for exactly the following cycle.
  - Writes to an address >= NUM_REGS are ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Reads are combinational, with zero latency from RA.
  - RA >= NUM_REGS reads 0; address 0 with ZERO_REG=1 reads 0.
  - BYPASS=1 and RA_i matches an enabled, valid write address in the same cycle: RD_i = that write data. If both ports match, WDB is returned.
  - BYPASS=0: RD_i returns the stored value; new data is visible the cycle after the edge.
- Scoreboard (NUM_REGS busy bits), updated on the rising edge:
  - A write on either port clears busy[addr].
  - SB_SET=1 sets busy[SB_ADDR].
  - Set and clear on the same address in the same cycle: set wins (a new producer replaces the old one).
  - SB_SET to address 0 with ZERO_REG=1, or to an address >= NUM_REGS, is ignored.
  - RBUSY_i = busy[RA_i], forced to 0 when BYPASS=1 and a same-cycle write to RA_i is enabled (data is being forwarded).
- No stall or back-pressure is generated internally; the consumer stalls on RBUSY.
- Out-of-range addresses never cause X propagation. All outputs are defined for all input combinations after reset.

Test Plan:
- Reset, then WEA=1, AA=3, WDA=0x0000000F for one edge; read RA0=3 -> RD0=0x0000000F. Assert rst=0 mid-cycle -> RD0=0 immediately, without waiting for a clk edge.
- BYPASS=1: WEA=1, AA=5, WDA=0x0000FFFF with RA1=5 in the same cycle -> RD1=0x0000FFFF before the edge. Repeat with BYPASS=0 -> RD1 stays old value 0 until after the edge.
- Same-address conflict: WEA=1, WEB=1, AA=AB=6, WDA=0x1, WDB=0x2 -> reg6=0x2 after the edge, WR_CONFLICT=1 for one cycle, then 0.
- ZERO_REG=1: WEA=1, AA=0, WDA=0xABCD; SB_SET=1, SB_ADDR=0 -> RD for address 0 = 0, RBUSY=0. Write 0xABCD to reg 1 -> RD for address 1 = 0xABCD.
- Scoreboard: SB_SET=1, SB_ADDR=7 -> RBUSY=1 for RA=7 on the next cycle. WEB=1, AB=7 with SB_SET=1, SB_ADDR=7 on the same edge -> stays busy. Later a WEA write to reg 7 alone -> busy cleared on the following cycle.
- Out of range with NUM_REGS=24: write to address 30 -> no register changes; RA=30 -> RD=0, RBUSY=0.
